// File: rtl/nios_pio_led_blink.sv
// Avalon-MM output PIO for the red LED bank, with atomic set/clear
// registers and a free-running blink engine that gates selected bits.
module nios_pio_led_blink #(
    parameter int               WIDTH        = 18,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter int               PERIOD_WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_BLINK  = 3'd1;
    localparam logic [2:0] A_PERIOD = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_SET    = 3'd4;
    localparam logic [2:0] A_CLR    = 3'd5;

    localparam logic [PERIOD_WIDTH-1:0] P_ONE = PERIOD_WIDTH'(1);

    logic [WIDTH-1:0]        data;
    logic [WIDTH-1:0]        blink_en;
    logic [PERIOD_WIDTH-1:0] period;
    logic [PERIOD_WIDTH-1:0] cnt;
    logic                    phase;     // 1 = ON, 0 = OFF
    logic [31:0]             rd_mux;

    logic wr_en;
    logic period_wr;
    logic [WIDTH-1:0] wd;

    assign wr_en     = chipselect & ~write_n;
    assign period_wr = wr_en && (address == A_PERIOD);
    assign wd        = writedata[WIDTH-1:0];

    // Upper writedata bits beyond WIDTH/PERIOD_WIDTH are intentionally dropped.
    logic unused_wd;
    assign unused_wd = &{1'b0, writedata};

    // Register file: DATA with atomic set/clear, BLINK_EN mask, PERIOD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data     <= RESET_VALUE;
            blink_en <= '0;
            period   <= '0;
        end else if (wr_en) begin
            case (address)
                A_DATA:   data     <= wd;
                A_BLINK:  blink_en <= wd;
                A_PERIOD: period   <= writedata[PERIOD_WIDTH-1:0];
                A_SET:    data     <= data | wd;
                A_CLR:    data     <= data & ~wd;
                default:  ;
            endcase
        end
    end

    // Blink engine: each phase lasts PERIOD cycles; a PERIOD write restarts ON.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (period_wr || period == '0) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (cnt == period - P_ONE) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + P_ONE;
        end
    end

    // Read mux; unused and write-only addresses read as zero.
    always_comb begin
        rd_mux = '0;
        case (address)
            A_DATA:   rd_mux = 32'(data);
            A_BLINK:  rd_mux = 32'(blink_en);
            A_PERIOD: rd_mux = 32'(period);
            A_STATUS: rd_mux = {30'd0, (period != '0), phase};
            default:  rd_mux = '0;
        endcase
    end

    // Registered read data and LED drive; blinking bits forced low while OFF.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            out_port <= RESET_VALUE;
        end else begin
            readdata <= rd_mux;
            out_port <= data & ~(blink_en & {WIDTH{~phase}});
        end
    end

endmodule

// File: tb/tb_nios_pio_led_blink.sv
// Scoreboard bench for nios_pio_led_blink: stimulus queues expected readdata
// and out_port values; a negedge monitor pops and compares them.
module tb_nios_pio_led_blink;

    localparam int WIDTH = 18;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [2:0]       address = '0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = '0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    always #5 clk = ~clk;

    nios_pio_led_blink #(
        .WIDTH(WIDTH), .RESET_VALUE('0), .PERIOD_WIDTH(24)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .out_port(out_port)
    );

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0]      rd_q[$];
    string            rd_n[$];
    logic [WIDTH-1:0] op_q[$];
    string            op_n[$];

    logic rd_strobe = 1'b0, op_strobe = 1'b0;
    logic rd_vld = 1'b0, op_vld = 1'b0;

    // Marks which edges produce a DUT output that the monitor should check.
    always @(posedge clk) begin
        rd_vld <= rd_strobe;
        op_vld <= op_strobe;
    end

    // Monitor: compare DUT outputs against the head of each queue.
    always @(negedge clk) begin
        logic [31:0]      er;
        logic [WIDTH-1:0] eo;
        string            nm;
        if (rd_vld) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_mis++;
                $display("FAIL rd_underflow: readdata=%h with no expectation", readdata);
            end else begin
                er = rd_q.pop_front(); nm = rd_n.pop_front();
                if (readdata !== er) begin
                    n_mis++;
                    $display("FAIL %s: readdata=%h expected %h", nm, readdata, er);
                end
            end
        end
        if (op_vld) begin
            n_cmp++;
            if (op_q.size() == 0) begin
                n_mis++;
                $display("FAIL op_underflow: out_port=%h with no expectation", out_port);
            end else begin
                eo = op_q.pop_front(); nm = op_n.pop_front();
                if (out_port !== eo) begin
                    n_mis++;
                    $display("FAIL %s: out_port=%h expected %h", nm, out_port, eo);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One bus cycle: inputs set before this call are sampled at the next posedge.
    task automatic cyc();
        @(negedge clk);
        rd_strobe  = 1'b0;
        op_strobe  = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        cyc();
    endtask

    task automatic wr_nocs(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b0; write_n = 1'b0; address = a; writedata = d;
        cyc();
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        rd_q.push_back(e); rd_n.push_back(nm);
        rd_strobe = 1'b1;
        cyc();
    endtask

    // Expect out_port value after the edge of the cycle issued next.
    task automatic exp_op(input logic [WIDTH-1:0] e, input string nm);
        op_q.push_back(e); op_n.push_back(nm);
        op_strobe = 1'b1;
    endtask

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ph;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_port", 32'(out_port), 32'h0);
        chk("rst_readdata", readdata, 32'h0);
        reset_n = 1'b1;

        exp_op(18'h0, "rst_out_after");
        rd(3'd0, 32'h0, "rst_data");
        rd(3'd1, 32'h0, "rst_blink_en");
        rd(3'd2, 32'h0, "rst_period");
        rd(3'd3, 32'h1, "rst_status");

        // Atomic set/clear
        wr(3'd0, 32'h3FFFF);
        wr(3'd5, 32'h0000F);
        exp_op(18'h3FFF0, "setclr_out_prev");
        wr(3'd4, 32'h00001);
        exp_op(18'h3FFF1, "setclr_out");
        rd(3'd0, 32'h3FFF1, "setclr_data");

        // Blink with PERIOD=4: 4 cycles ON (0x3), 4 cycles OFF (0x2)
        wr(3'd0, 32'h3);
        wr(3'd1, 32'h1);
        wr(3'd2, 32'h4);
        for (int i = 1; i <= 11; i++) begin
            ph = (((i - 1) / 4) % 2) == 0;
            exp_op(ph ? 18'h3 : 18'h2, "blink4_out");
            rd(3'd3, ph ? 32'h3 : 32'h2, "blink4_status");
        end
        // Counter is 3 here: PERIOD write coincides with the wrap and wins
        exp_op(18'h3, "p2_wr_out");
        wr(3'd2, 32'h2);
        for (int j = 1; j <= 6; j++) begin
            ph = (((j - 1) / 2) % 2) == 0;
            exp_op(ph ? 18'h3 : 18'h2, "blink2_out");
            rd(3'd3, ph ? 32'h3 : 32'h2, "blink2_status");
        end
        exp_op(18'h2, "off_out");
        cyc();

        // Asynchronous reset during OFF phase
        reset_n = 1'b0;
        #1;
        chk("async_rst_out", 32'(out_port), 32'h0);
        chk("async_rst_rd", readdata, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rd(3'd1, 32'h0, "post_rst_blink_en");
        rd(3'd2, 32'h0, "post_rst_period");
        wr(3'd0, 32'h3);
        for (int i = 0; i < 10; i++) begin
            exp_op(18'h3, "post_rst_no_blink");
            rd(3'd3, 32'h1, "post_rst_status");
        end

        // Ignored writes: chipselect low, STATUS and reserved addresses
        wr_nocs(3'd0, 32'h15555);
        wr_nocs(3'd1, 32'h3FFFF);
        wr_nocs(3'd2, 32'h5);
        wr(3'd3, 32'hFFFFFFFF);
        wr(3'd6, 32'hFFFFFFFF);
        wr(3'd7, 32'hFFFFFFFF);
        exp_op(18'h3, "ignored_out");
        rd(3'd0, 32'h3, "ignored_data");
        rd(3'd1, 32'h0, "ignored_blink_en");
        rd(3'd2, 32'h0, "ignored_period");
        rd(3'd3, 32'h1, "ignored_status");
        rd(3'd4, 32'h0, "rd_outset");
        rd(3'd5, 32'h0, "rd_outclear");
        rd(3'd6, 32'h0, "rd_res6");
        rd(3'd7, 32'h0, "rd_res7");

        cyc();
        cyc();
        chk("rd_q_drained", 32'(rd_q.size()), 32'h0);
        chk("op_q_drained", 32'(op_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/nios_pio_led_blink.md
# nios_pio_led_blink

Avalon-MM slave output PIO that drives the DE2-115 red LED bank from the Nios II. It is the write-direction counterpart of the system's read-only input PIO. It adds atomic bit-set/bit-clear registers and a hardware blink engine, so software can flash selected LEDs without polling. It sits on the Nios data master via the Qsys interconnect, and `out_port` goes straight to the board's LEDR pins.

## Interface
- `WIDTH`, 18: number of output bits in `out_port` and in the data and mask registers.
- `RESET_VALUE`, 0: value loaded into DATA on reset.
- `PERIOD_WIDTH`, 24: width of the blink half-period register and its counter.

- `clk`  in  1  system clock. Reset is `reset_n`, asynchronous, active-low, on clock `clk`.
- `reset_n`  in  1  asynchronous active-low reset.
- `address`  in  3  word address of the register being accessed.
- `chipselect`  in  1  slave select; a write is accepted only when it is high.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data; only bits [WIDTH-1:0] are used, except for PERIOD.
- `readdata`  out  32  registered read data, zero-extended.
- `out_port`  out  WIDTH  registered LED drive.

## Operation
- Register map (word address):
  - 0 DATA, RW.
  - 1 BLINK_EN, RW mask.
  - 2 PERIOD, RW, [PERIOD_WIDTH-1:0].
  - 3 STATUS, RO: bit0 = phase, bit1 = (PERIOD != 0).
  - 4 OUTSET, WO.
  - 5 OUTCLEAR, WO.
  - 6 and 7: reserved.
- Write acceptance: a write is accepted on a clk edge when `chipselect`=1 and `write_n`=0. There are no wait states.
- DATA write: DATA <= writedata[WIDTH-1:0].
- OUTSET write: DATA <= DATA | writedata[WIDTH-1:0].
- OUTCLEAR write: DATA <= DATA & ~writedata[WIDTH-1:0].
- BLINK_EN write: BLINK_EN <= writedata[WIDTH-1:0].
- PERIOD write: PERIOD <= writedata[PERIOD_WIDTH-1:0]. In the same cycle the counter is forced to 0 and phase to 1.
- Writes to STATUS, 6 or 7 are ignored.
- Read mux: readdata is loaded every clk edge from the mux selected by `address`, regardless of `chipselect`.
  - OUTSET, OUTCLEAR, 6 and 7 read 0.
  - Unused upper bits read 0.
- Blink engine (two states of `phase`: ON=1, OFF=0):
  - PERIOD=0: counter held at 0 and phase held at ON.
  - PERIOD=P>0: counter increments each cycle.
  - When counter == P-1, the counter wraps to 0 and phase toggles on that same edge.
  - Each phase therefore lasts exactly P cycles.
- Output: out_port <= DATA & ~(BLINK_EN & {WIDTH{~phase}}).
  - Blinking bits follow DATA during ON and are forced 0 during OFF.
  - Non-blinking bits always follow DATA.
- Simultaneous events:
  - A PERIOD write in the same cycle as a wrap: the write wins (counter 0, phase ON).
  - A DATA, OUTSET or OUTCLEAR write in the same cycle as a phase toggle: both take effect; out_port combines the new DATA with the new phase.
  - Only one register is written per cycle, so there are no read-modify-write hazards.
- Reset (asynchronous, any time, including mid-blink):
  - DATA = RESET_VALUE.
  - BLINK_EN = 0, PERIOD = 0, counter = 0, phase = ON.
  - out_port = RESET_VALUE, readdata = 0.

## Timing
- Write path:
  - A write sampled at edge k updates its register at edge k.
  - out_port reflects the change at edge k+1, a one-cycle write-to-pin latency.
- Read path:
  - Address presented before edge k gives readdata valid after edge k, a fixed read latency of 1.
  - STATUS read at edge k returns the phase value held just before edge k.
- Blink path:
  - Counter wrap at edge k toggles phase at edge k; out_port changes at edge k+1.
  - The out_port period is 2P cycles with a 50% duty cycle.
- After reset deassertion, the first accepted write may occur on the first clk edge.

## Test plan
- Reset, then read addresses 0–3 -> readdata 0, 0, 0, 0x1; out_port = 0.
- Write DATA=0x3FFFF, then OUTCLEAR=0x0000F, then OUTSET=0x00001 -> DATA reads 0x3FFF1; out_port = 0x3FFF1 one cycle after the last write.
- DATA=0x00003, BLINK_EN=0x00001, PERIOD=4 -> out_port alternates 0x00003 and 0x00002, each value held for exactly 4 cycles; STATUS bit0 toggles every 4 cycles.
- Mid-blink, write PERIOD=2 in the cycle the counter hits 3 -> phase is ON and the counter is 0 after the edge; the new period is 2 cycles per phase.
- Assert reset_n=0 asynchronously during the OFF phase -> out_port = RESET_VALUE immediately; after release there is no blinking until BLINK_EN and PERIOD are rewritten.
- Write with chipselect=0, and write to address 3/6/7 -> no register changes; reads of 4–7 return 0.
